// File: rtl/jtag_scan_master.sv
// JTAG scan master: TAP reset sequence plus IR/DR scans of up to MAX_LEN bits. Optional RTI tail: JTAG_SCAN_RTI_EN.
// Latency: (len+5, +1 for IR, +RTI_CYCLES if enabled) TCK periods of 2*CLK_DIV clk_i cycles, response on the next cycle.
// Backpressure: req_ready_o only in IDLE; the response is held until rsp_ready_i, so no new request is taken meanwhile.
module jtag_scan_master #(
    parameter int MAX_LEN    = 64,
    parameter int CLK_DIV    = 2,
    parameter int RTI_CYCLES = 4
) (
    input  logic                         clk_i,
    input  logic                         ntrst_i,
    input  logic                         req_valid_i,
    output logic                         req_ready_o,
    input  logic                         req_ir_i,
    input  logic [$clog2(MAX_LEN+1)-1:0] req_len_i,
    input  logic [MAX_LEN-1:0]           req_data_i,
    output logic                         rsp_valid_o,
    input  logic                         rsp_ready_i,
    output logic [MAX_LEN-1:0]           rsp_data_o,
    output logic                         rsp_err_o,
    input  logic                         tap_reset_i,
    output logic                         busy_o,
    output logic                         tck_o,
    output logic                         tms_o,
    output logic                         tdi_o,
    input  logic                         tdo_i
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int CNT_W = $clog2(MAX_LEN + RTI_CYCLES + 8);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);

    localparam logic [2:0] S_RST   = 3'd0;
    localparam logic [2:0] S_IDLE  = 3'd1;
    localparam logic [2:0] S_HDR   = 3'd2;
    localparam logic [2:0] S_SHIFT = 3'd3;
    localparam logic [2:0] S_TRL   = 3'd4;
    localparam logic [2:0] S_RTI   = 3'd5;
    localparam logic [2:0] S_RESP  = 3'd6;

    logic [2:0]         state;
    logic [DIV_W-1:0]   div_cnt;
    logic               tck_q;
    logic               tms_q;
    logic [CNT_W-1:0]   bit_cnt;
    logic               ir_q;
    logic [LEN_W-1:0]   len_q;
    logic [MAX_LEN-1:0] data_sh;
    logic [MAX_LEN-1:0] cap;
    logic               err_q;

    logic               active;
    logic               tick;
    logic               rise;
    logic               fall;
    logic               last_bit;
    logic [2:0]         end_state;
    logic [2:0]         nxt_state;
    logic [CNT_W-1:0]   nxt_cnt;
    logic [CNT_W-1:0]   len_c;
    logic               tms_nxt;

    assign active = (state == S_RST) || (state == S_HDR) || (state == S_SHIFT) ||
                    (state == S_TRL) || (state == S_RTI);
    assign tick   = active && (div_cnt == DIV_W'(CLK_DIV - 1));
    assign rise   = tick && !tck_q;
    assign fall   = tick && tck_q;
    assign len_c  = CNT_W'(len_q);

    // Every TCK cycle is a low phase then a high phase; the state advances on the falling edge.
    always_comb begin
        last_bit  = 1'b0;
        end_state = state;
        case (state)
            S_RST: begin
                last_bit  = (bit_cnt == CNT_W'(5));
                end_state = S_IDLE;
            end
            S_HDR: begin
                last_bit  = (bit_cnt == (ir_q ? CNT_W'(3) : CNT_W'(2)));
                end_state = S_SHIFT;
            end
            S_SHIFT: begin
                last_bit  = (bit_cnt == len_c - CNT_W'(1));
                end_state = S_TRL;
            end
            S_TRL: begin
                last_bit  = (bit_cnt == CNT_W'(1));
`ifdef JTAG_SCAN_RTI_EN
                end_state = S_RTI;
`else
                end_state = S_RESP;
`endif
            end
`ifdef JTAG_SCAN_RTI_EN
            S_RTI: begin
                last_bit  = (bit_cnt == CNT_W'(RTI_CYCLES - 1));
                end_state = S_RESP;
            end
`endif
            default: ;
        endcase
        nxt_state = last_bit ? end_state : state;
        nxt_cnt   = last_bit ? '0 : bit_cnt + CNT_W'(1);

        tms_nxt = 1'b0;
        case (nxt_state)
            S_RST:   tms_nxt = (nxt_cnt < CNT_W'(5));
            S_HDR:   tms_nxt = ir_q ? (nxt_cnt < CNT_W'(2)) : (nxt_cnt == '0);
            S_SHIFT: tms_nxt = (nxt_cnt == len_c - CNT_W'(1));
            S_TRL:   tms_nxt = (nxt_cnt == '0);
            default: tms_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge ntrst_i) begin
        if (!ntrst_i) begin
            state   <= S_RST;
            div_cnt <= '0;
            tck_q   <= 1'b0;
            tms_q   <= 1'b1;
            bit_cnt <= '0;
            ir_q    <= 1'b0;
            len_q   <= '0;
            data_sh <= '0;
            cap     <= '0;
            err_q   <= 1'b0;
        end else begin
            div_cnt <= (active && !tick) ? div_cnt + DIV_W'(1) : '0;
            if (tick) tck_q <= ~tck_q;
            if (rise && state == S_SHIFT) cap <= {tdo_i, cap[MAX_LEN-1:1]};
            if (fall) begin
                state   <= nxt_state;
                bit_cnt <= nxt_cnt;
                tms_q   <= tms_nxt;
                if (state == S_SHIFT) begin
                    data_sh <= data_sh >> 1;
                    // Captured bits entered from the top; right-align them once the shift ends.
                    if (last_bit) cap <= cap >> (MAX_L - len_q);
                end
            end
            case (state)
                S_IDLE: begin
                    if (tap_reset_i) begin
                        state   <= S_RST;
                        bit_cnt <= '0;
                        tms_q   <= 1'b1;
                    end else if (req_valid_i) begin
                        ir_q    <= req_ir_i;
                        len_q   <= req_len_i;
                        data_sh <= req_data_i;
                        cap     <= '0;
                        bit_cnt <= '0;
                        if (req_len_i == '0 || req_len_i > MAX_L) begin
                            err_q <= 1'b1;
                            state <= S_RESP;
                        end else begin
                            err_q <= 1'b0;
                            state <= S_HDR;
                            tms_q <= 1'b1;
                        end
                    end
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        state <= S_IDLE;
                        err_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign tck_o       = tck_q;
    assign tms_o       = tms_q;
    assign tdi_o       = (state == S_SHIFT) && data_sh[0];
    assign busy_o      = (state != S_IDLE);
    assign req_ready_o = (state == S_IDLE) && !tap_reset_i;
    assign rsp_valid_o = (state == S_RESP);
    assign rsp_data_o  = (state == S_RESP) ? cap : '0;
    assign rsp_err_o   = err_q;

endmodule
